// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered sign/zero/upper immediate extend plus 0..3 left shift behind a 2-entry skid.
// Optional IMM_EXT_ERR_EN: mode 11 beats carry data_o=0 and err_o=1.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
)(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [IN_W-1:0]  data_i,
  input  logic [1:0]       mode_i,
  input  logic [1:0]       sh_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [OUT_W-1:0] data_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             err_o
);
  localparam int BW = OUT_W + TAG_W + 1;
  localparam logic [1:0] EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2;
  logic [1:0]       r_state;
  logic [BW-1:0]    r_out, r_skid, w_beat;
  logic [OUT_W-1:0] w_sign, w_zero, w_upper, w_ext;
  logic             w_err, w_acc, w_drain;
  generate
    if (OUT_W == IN_W) begin : g_pass
      assign w_sign  = data_i;
      assign w_zero  = data_i;
      assign w_upper = data_i;
    end else begin : g_ext
      assign w_sign  = {{(OUT_W-IN_W){data_i[IN_W-1]}}, data_i};
      assign w_zero  = {{(OUT_W-IN_W){1'b0}}, data_i};
      assign w_upper = {data_i, {(OUT_W-IN_W){1'b0}}};
    end
  endgenerate
`ifdef IMM_EXT_ERR_EN
  assign w_err = &mode_i;
`else
  assign w_err = 1'b0;
`endif
  always_comb w_ext = w_err ? '0 : mode_i == 2'b01 ? w_zero : mode_i == 2'b10 ? w_upper : w_sign;
  assign w_beat  = {w_err, tag_i, w_ext << sh_i};
  assign ready_o = r_state != TWO;
  assign valid_o = r_state != EMPTY;
  assign w_acc   = valid_i & ready_o;
  assign w_drain = valid_o & ready_i;
  assign {err_o, tag_o, data_o} = r_out;
  // state encodes occupancy, so it simply tracks accepts minus drains
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= EMPTY;
      r_out   <= '0;
    end else begin
      r_state <= r_state + {1'b0, w_acc} - {1'b0, w_drain};
      if (w_acc && (r_state == EMPTY || w_drain)) r_out <= w_beat;
      else if (r_state == TWO && w_drain) r_out <= r_skid;
    end
  end
  always_ff @(posedge clk_i)
    if (w_acc && r_state == ONE && !w_drain) r_skid <= w_beat;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: random and directed stimulus checked against an arithmetic model and FIFO scoreboard.
module tb_imm_extend_pipe;
  logic        clk_i = 0, rst_i = 1, valid_i = 0, ready_i = 0;
  logic [15:0] data_i = 0;
  logic [1:0]  mode_i = 0, sh_i = 0;
  logic [4:0]  tag_i = 0;
  logic        ready_o, valid_o, err_o;
  logic [31:0] data_o;
  logic [4:0]  tag_o;
  int checks = 0, passed = 0;
  logic [37:0] q[$];
  logic [37:0] exp_beat;
  bit done = 0;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .mode_i(mode_i), .sh_i(sh_i), .tag_i(tag_i), .valid_o(valid_o), .ready_i(ready_i),
    .data_o(data_o), .tag_o(tag_o), .err_o(err_o));

  always #5 clk_i = ~clk_i;

  function automatic logic model_err(input logic [1:0] m);
`ifdef IMM_EXT_ERR_EN
    return m == 2'b11;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model(input logic [15:0] d, input logic [1:0] m, input logic [1:0] s);
    longint v;
    if (model_err(m)) return 32'h0;
    v = (m == 2'b01) ? longint'(d) : (m == 2'b10) ? longint'(d) * 65536 : longint'($signed(d));
    v = v * (2 ** s);
    return v[31:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk_i) begin
    if (rst_i) q.delete();
    else begin
      chk("ready_o vs occupancy", 64'(ready_o), 64'(q.size() < 2));
      chk("valid_o vs occupancy", 64'(valid_o), 64'(q.size() > 0));
      if (valid_o && q.size() > 0) begin
        exp_beat = q[0];
        chk("beat", {26'h0, err_o, tag_o, data_o}, {26'h0, exp_beat});
        if (ready_i) void'(q.pop_front());
      end
      if (valid_i && ready_o) q.push_back({model_err(mode_i), tag_i, model(data_i, mode_i, sh_i)});
    end
  end

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic send(input logic [15:0] d, input logic [1:0] m, input logic [1:0] s, input logic [4:0] t);
    int n = 0;
    valid_i = 1; data_i = d; mode_i = m; sh_i = s; tag_i = t;
    forever begin
      @(negedge clk_i);
      if (ready_o) break;
      if (++n > 200) begin
        chk("send timeout", 64'(n), 64'(0));
        break;
      end
    end
    step();
    valid_i = 0;
  endtask

  task automatic drain();
    int n = 0;
    ready_i = 1;
    while (q.size() > 0 && n < 50) begin step(); n++; end
    chk("drain empty", 64'(q.size()), 64'(0));
  endtask

  initial begin
    int t0;
    chk("model sign", 64'(model(16'h8004, 2'b00, 2'd0)), 64'h0000_0000_FFFF_8004);
    chk("model zero sh2", 64'(model(16'h8004, 2'b01, 2'd2)), 64'h0000_0000_0002_0010);
    chk("model upper", 64'(model(16'h8004, 2'b10, 2'd0)), 64'h0000_0000_8004_0000);
    chk("model upper sh1", 64'(model(16'h8004, 2'b10, 2'd1)), 64'h0000_0000_0008_0000);
    repeat (2) step();
    rst_i = 0;
    @(negedge clk_i);
    chk("rst valid_o", 64'(valid_o), 64'(0));
    chk("rst ready_o", 64'(ready_o), 64'(1));
    chk("rst data/tag/err", {26'h0, err_o, tag_o, data_o}, 64'h0);
    step();
    ready_i = 1;
    send(16'h8004, 2'b00, 2'd0, 5'd7);
    @(negedge clk_i);
    chk("t1 valid_o", 64'(valid_o), 64'(1));
    chk("t1 data_o", 64'(data_o), 64'hFFFF_8004);
    chk("t1 tag_o", 64'(tag_o), 64'd7);
    step();
    send(16'h8004, 2'b01, 2'd2, 5'd1);
    send(16'h8004, 2'b10, 2'd0, 5'd2);
    send(16'h8004, 2'b10, 2'd1, 5'd3);
    @(negedge clk_i);
    chk("t2 data_o", 64'(data_o), 64'h0008_0000);
    drain();
    ready_i = 0;
    send(16'h0001, 2'b00, 2'd0, 5'd1);
    send(16'h0002, 2'b00, 2'd0, 5'd2);
    @(negedge clk_i);
    chk("t3 ready_o low", 64'(ready_o), 64'(0));
    chk("t3 head tag", 64'(tag_o), 64'd1);
    step();
    ready_i = 1;
    send(16'h0003, 2'b00, 2'd0, 5'd3);
    drain();
    ready_i = 0;
    send(16'h1111, 2'b01, 2'd0, 5'd9);
    send(16'h2222, 2'b01, 2'd0, 5'd10);
    rst_i = 1;
    step();
    rst_i = 0;
    @(negedge clk_i);
    chk("t4 valid_o", 64'(valid_o), 64'(0));
    chk("t4 data_o", 64'(data_o), 64'h0);
    chk("t4 ready_o", 64'(ready_o), 64'(1));
    ready_i = 1;
    repeat (4) step();
    t0 = $time;
    for (int i = 0; i < 100; i++)
      send(16'($urandom), 2'($urandom_range(0, 2)), 2'($urandom), 5'($urandom));
    chk("t5 throughput cycles", 64'(($time - t0) / 10), 64'd100);
    drain();
    send(16'h1234, 2'b11, 2'd0, 5'd4);
    @(negedge clk_i);
`ifdef IMM_EXT_ERR_EN
    chk("t6 data_o", 64'(data_o), 64'h0);
    chk("t6 err_o", 64'(err_o), 64'(1));
`else
    chk("t6 data_o", 64'(data_o), 64'h0000_1234);
    chk("t6 err_o", 64'(err_o), 64'(0));
`endif
    drain();
    fork
      begin
        for (int i = 0; i < 200; i++)
          send(16'($urandom), 2'($urandom), 2'($urandom), 5'($urandom));
        done = 1;
      end
      while (!done) begin
        step();
        ready_i = 1'($urandom_range(0, 1));
      end
    join
    drain();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
